// File: rtl/ternary_neuron_seq.sv
// ternary_neuron_seq
//   Evaluates one ternary neuron over up to N_CHUNKS x 27 input bits by
//   time-multiplexing a single external 27-input popcount unit. Each chunk
//   takes two passes: popcount(x & wpos) is added, then popcount(x & wneg)
//   is subtracted. The saturating signed sum is compared against a
//   threshold that is captured on the first beat of the neuron.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    chunk beat handshake (ready only while idle)
//   in_x/in_wpos/in_wneg chunk activation bits and weight masks
//   in_last              final chunk of this neuron
//   in_thr               signed threshold, sampled on the first beat only
//   pc_in/pc_out         operand to / result from the shared popcount unit
//   out_valid/out_ready  result handshake
//   out_act              1 when sum >= thr
//   out_sum              signed accumulated sum
//   out_nchunks          chunks consumed for this neuron
//   out_ovf              saturation occurred or chunk limit forced the end
module ternary_neuron_seq #(
  parameter int unsigned N_CHUNKS = 4,
  parameter int unsigned ACC_W    = 9,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [26:0]      in_x,
  input  logic [26:0]      in_wpos,
  input  logic [26:0]      in_wneg,
  input  logic             in_last,
  input  logic [ACC_W-1:0] in_thr,
  output logic [26:0]      pc_in,
  input  logic [4:0]       pc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_act,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_nchunks,
  output logic             out_ovf
);

  localparam int unsigned EW = ACC_W + 2;

  // Clamp limits held in the widened arithmetic domain.
  localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_POS, S_NEG, S_DONE} state_t;

  state_t                  r_state;
  logic [26:0]             r_x;
  logic [26:0]             r_wpos;
  logic [26:0]             r_wneg;
  logic                    r_last;
  logic signed [ACC_W-1:0] r_thr;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_first;
  logic                    r_ovf;

  logic signed [EW-1:0]    w_acc_ext;
  logic signed [EW-1:0]    w_pc_ext;
  logic signed [EW-1:0]    w_sum;
  logic signed [ACC_W-1:0] w_acc_sat;
  logic                    w_clamp;
  logic                    w_at_limit;
  logic                    w_ovf_neg;

  assign in_ready = (r_state == S_IDLE);

  // The shared unit only sees a non-zero operand during the two passes.
  always_comb begin
    pc_in = '0;
    if (r_state == S_POS) pc_in = r_x & r_wpos;
    if (r_state == S_NEG) pc_in = r_x & r_wneg;
  end

  // Two guard bits keep a full 5-bit popcount (up to 31) from wrapping
  // before the clamp is applied.
  always_comb begin
    w_acc_ext = {{2{r_acc[ACC_W-1]}}, r_acc};
    w_pc_ext  = {{(EW-5){1'b0}}, pc_out};
    w_sum     = (r_state == S_NEG) ? (w_acc_ext - w_pc_ext) : (w_acc_ext + w_pc_ext);
    w_clamp   = 1'b0;
    w_acc_sat = w_sum[ACC_W-1:0];
    if (w_sum > SAT_MAX) begin
      w_acc_sat = SAT_MAX[ACC_W-1:0];
      w_clamp   = 1'b1;
    end else if (w_sum < SAT_MIN) begin
      w_acc_sat = SAT_MIN[ACC_W-1:0];
      w_clamp   = 1'b1;
    end
  end

  assign w_at_limit = (r_cnt == CNT_W'(N_CHUNKS));
  assign w_ovf_neg  = r_ovf | w_clamp | (w_at_limit & ~r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_wpos      <= '0;
      r_wneg      <= '0;
      r_last      <= 1'b0;
      r_thr       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_ovf       <= 1'b0;
      out_valid   <= 1'b0;
      out_act     <= 1'b0;
      out_sum     <= '0;
      out_nchunks <= '0;
      out_ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x     <= in_x;
            r_wpos  <= in_wpos;
            r_wneg  <= in_wneg;
            r_last  <= in_last;
            r_first <= 1'b0;
            r_state <= S_POS;
            if (r_first) begin
              r_thr <= in_thr;
              r_acc <= '0;
              r_ovf <= 1'b0;
              r_cnt <= CNT_W'(1);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_POS: begin
          r_acc   <= w_acc_sat;
          r_ovf   <= r_ovf | w_clamp;
          r_state <= S_NEG;
        end
        S_NEG: begin
          r_acc <= w_acc_sat;
          r_ovf <= w_ovf_neg;
          if (r_last || w_at_limit) begin
            // Result registers load from the final (post-subtract) value so
            // out_valid rises together with the DONE state.
            r_state     <= S_DONE;
            out_valid   <= 1'b1;
            out_sum     <= w_acc_sat;
            out_act     <= (w_acc_sat >= r_thr);
            out_nchunks <= r_cnt;
            out_ovf     <= w_ovf_neg;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_first   <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_neuron_seq.sv
// tb_ternary_neuron_seq
//   Directed bench for ternary_neuron_seq. The main instance is paired with
//   an exact popcount model; a second instance with ACC_W=6 uses a stub
//   that returns 31 for any non-zero operand to exercise saturation.
module tb_ternary_neuron_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] in_x = '0;
  logic [26:0] in_wpos = '0;
  logic [26:0] in_wneg = '0;
  logic        in_last = 1'b0;
  logic [8:0]  in_thr = '0;
  logic [26:0] pc_in;
  logic [4:0]  pc_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_act;
  logic [8:0]  out_sum;
  logic [2:0]  out_nchunks;
  logic        out_ovf;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic        s_in_last = 1'b0;
  logic [5:0]  s_in_thr = '0;
  logic [26:0] s_pc_in;
  logic [4:0]  s_pc_out;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic        s_out_act;
  logic [5:0]  s_out_sum;
  logic [2:0]  s_out_nchunks;
  logic        s_out_ovf;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign pc_out   = 5'($countones(pc_in));
  assign s_pc_out = (s_pc_in != '0) ? 5'd31 : 5'd0;

  ternary_neuron_seq #(.N_CHUNKS(4), .ACC_W(9), .CNT_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_wpos(in_wpos), .in_wneg(in_wneg),
    .in_last(in_last), .in_thr(in_thr),
    .pc_in(pc_in), .pc_out(pc_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_act(out_act), .out_sum(out_sum),
    .out_nchunks(out_nchunks), .out_ovf(out_ovf)
  );

  ternary_neuron_seq #(.N_CHUNKS(4), .ACC_W(6), .CNT_W(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_x(27'h7FFFFFF), .in_wpos(27'h7FFFFFF), .in_wneg(27'h0),
    .in_last(s_in_last), .in_thr(s_in_thr),
    .pc_in(s_pc_in), .pc_out(s_pc_out),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_act(s_out_act), .out_sum(s_out_sum),
    .out_nchunks(s_out_nchunks), .out_ovf(s_out_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_beat(input logic [26:0] x, input logic [26:0] wp,
                           input logic [26:0] wn, input logic last,
                           input int thr);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_x     = x;
    in_wpos  = wp;
    in_wneg  = wn;
    in_last  = last;
    in_thr   = 9'(thr);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string name, input int e_sum, input int e_act,
                            input int e_n, input int e_ovf);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_sum"}, int'($signed(out_sum)), e_sum);
    chk({name, "_act"}, int'(out_act), e_act);
    chk({name, "_n"}, int'(out_nchunks), e_n);
    chk({name, "_ovf"}, int'(out_ovf), e_ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [26:0] x;
    logic [26:0] wp;
    logic [26:0] wn;
    logic        last;
    int          thr;
    logic        do_chk;
    int          e_sum;
    int          e_act;
    int          e_n;
    int          e_ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // single-chunk neurons
    tbl[0] = '{27'h7FFFFFF, 27'h7FFFFFF, 27'h0,       1'b1,  20, 1'b1,  27, 1, 1, 0};
    tbl[1] = '{27'h00000FF, 27'h000000F, 27'h00000F0, 1'b1,   0, 1'b1,   0, 1, 1, 0};
    tbl[2] = '{27'h7FFFFFF, 27'h0,       27'h00003FF, 1'b1, -10, 1'b1, -10, 1, 1, 0};
    tbl[3] = '{27'h7FFFFFF, 27'h00000FF, 27'h00000FF, 1'b1,   1, 1'b1,   0, 0, 1, 0};
    // four chunks of (+5 -9); later thr values must be ignored
    tbl[4] = '{27'h7FFFFFF, 27'h000001F, 27'h7FC0000, 1'b0, -10, 1'b0,   0, 0, 0, 0};
    tbl[5] = '{27'h7FFFFFF, 27'h000001F, 27'h7FC0000, 1'b0, -20, 1'b0,   0, 0, 0, 0};
    tbl[6] = '{27'h7FFFFFF, 27'h000001F, 27'h7FC0000, 1'b0, -20, 1'b0,   0, 0, 0, 0};
    tbl[7] = '{27'h7FFFFFF, 27'h000001F, 27'h7FC0000, 1'b1, -20, 1'b1, -16, 0, 4, 0};
    // two chunks: 27 + 27 - 3
    tbl[8] = '{27'h7FFFFFF, 27'h7FFFFFF, 27'h0,       1'b0,  50, 1'b0,   0, 0, 0, 0};
    tbl[9] = '{27'h7FFFFFF, 27'h7FFFFFF, 27'h0000007, 1'b1,  50, 1'b1,  51, 1, 2, 0};

    // reset state
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_pc_in", int'(pc_in), 0);
    chk("rst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // first-result latency: handshake edge, POS edge, NEG edge -> valid
    send_beat(27'h7FFFFFF, 27'h7FFFFFF, 27'h0, 1'b1, 20);
    chk("lat_pos_valid", int'(out_valid), 0);
    chk("lat_pos_pc", int'(pc_in), 27'h7FFFFFF);
    @(negedge clk);
    chk("lat_neg_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_done_valid", int'(out_valid), 1);
    get_result("lat", 27, 1, 1, 0);

    for (int i = 0; i < 10; i++) begin
      send_beat(tbl[i].x, tbl[i].wp, tbl[i].wn, tbl[i].last, tbl[i].thr);
      if (tbl[i].do_chk)
        get_result($sformatf("tbl%0d", i), tbl[i].e_sum, tbl[i].e_act,
                   tbl[i].e_n, tbl[i].e_ovf);
    end

    // chunk limit: four beats without last end the neuron with ovf
    for (int i = 0; i < 4; i++)
      send_beat(27'h7FFFFFF, 27'h0000007, 27'h0, 1'b0, 12);
    get_result("limit", 12, 1, 4, 1);
    // next beat opens a new neuron with a fresh threshold
    send_beat(27'h7FFFFFF, 27'h0000001, 27'h0, 1'b0, 1);
    send_beat(27'h7FFFFFF, 27'h0000001, 27'h0, 1'b1, 99);
    get_result("after_limit", 2, 1, 2, 0);

    // result held under back-pressure; beats offered meanwhile are ignored
    send_beat(27'h7FFFFFF, 27'h000003F, 27'h0000003, 1'b1, 4);
    repeat (2) @(negedge clk);
    begin
      int bad = 0;
      in_valid = 1'b1;
      in_wpos  = 27'h7FFFFFF;
      for (int c = 0; c < 10; c++) begin
        if (out_valid !== 1'b1 || $signed(out_sum) != 4 || out_act !== 1'b1 ||
            in_ready !== 1'b0 || pc_in != '0) bad++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk("hold_stable_bad_cycles", bad, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", int'(out_valid), 0);
    chk("release_ready", int'(in_ready), 1);
    repeat (5) @(negedge clk);
    chk("stall_ready", int'(in_ready), 1);
    chk("stall_pc_in", int'(pc_in), 0);

    // saturation on the narrow instance: 31 + 31 clamps to 31
    for (int b = 0; b < 2; b++) begin
      int n = 0;
      while (!s_in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      s_in_last  = (b == 1);
      s_in_thr   = 6'd0;
      s_in_valid = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
    end
    begin
      int n = 0;
      while (!s_out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("sat_valid", int'(s_out_valid), 1);
    chk("sat_sum", int'($signed(s_out_sum)), 31);
    chk("sat_ovf", int'(s_out_ovf), 1);
    chk("sat_n", int'(s_out_nchunks), 2);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;

    // reset during NEG of chunk 2 discards the partial neuron
    send_beat(27'h7FFFFFF, 27'h00003FF, 27'h0, 1'b0, 0);
    send_beat(27'h7FFFFFF, 27'h00003FF, 27'h0000007, 1'b1, 0);
    @(negedge clk);
    chk("pre_rst_pc_in", int'(pc_in), 7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_sum", int'(out_sum), 0);
    chk("mid_rst_pc_in", int'(pc_in), 0);
    chk("mid_rst_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(27'h7FFFFFF, 27'h000001F, 27'h0000003, 1'b1, 3);
    get_result("post_rst", 3, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
